// File: rtl/alu_seq_if.sv
// Handshaked operand/result bundle between decode, the sequential ALU core and write-back.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_c;
    logic             flag_v;
    logic             flag_z;
    logic             flag_cmp;
    logic             flag_err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi,
               flag_c, flag_v, flag_z, flag_cmp, flag_err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi,
               flag_c, flag_v, flag_z, flag_cmp, flag_err
    );
endinterface

// File: rtl/alu_seq_core.sv
// Registered ALU with valid/ready handshake: single-cycle logic/arith ops plus an
// iterative shift-add multiply that occupies the core for WIDTH cycles.
module alu_seq_core #(
    parameter int WIDTH      = 8,
    parameter bit MUL_ENABLE = 1'b1
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int MSB   = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_SHL = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_ROL = 4'h6;
    localparam logic [3:0] OP_EQ  = 4'h7;
    localparam logic [3:0] OP_GT  = 4'h8;
    localparam logic [3:0] OP_LT  = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               c_q, c_d, v_q, v_d, z_q, z_d, cmp_q, cmp_d, err_q, err_d;

    logic               in_ready_w;
    logic               accept;
    logic               is_mul_op;

    logic [WIDTH:0]     sum;
    logic [CNT_W-1:0]   rot, rot_inv;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_c, sc_v, sc_z, sc_cmp, sc_err;

    assign in_ready_w = (state_q == S_IDLE) & (~out_valid_q | bus.out_ready);
    assign accept     = bus.in_valid & in_ready_w;
    assign is_mul_op  = MUL_ENABLE && (bus.op == OP_MUL);

    // Single-cycle result path, evaluated from the live operands at accept.
    always_comb begin
        sum     = '0;
        rot     = bus.b[CNT_W-1:0];
        rot_inv = CNT_W'(0) - rot;
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        sc_cmp  = 1'b0;
        sc_err  = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sum    = {1'b0, bus.a} + {1'b0, bus.b};
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (bus.a[MSB] == bus.b[MSB]) && (sc_res[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                sum    = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (bus.a[MSB] != bus.b[MSB]) && (sc_res[MSB] != bus.a[MSB]);
            end
            OP_SHL: sc_res = (32'(bus.b) >= WIDTH) ? '0 : (bus.a << bus.b);
            OP_OR:  sc_res = bus.a | bus.b;
            OP_AND: sc_res = bus.a & bus.b;
            OP_XOR: sc_res = bus.a ^ bus.b;
            // rot_inv wraps to 0 for rot==0, so the OR degenerates to a itself.
            OP_ROL: sc_res = (bus.a << rot) | (bus.a >> rot_inv);
            OP_EQ:  sc_cmp = (bus.a == bus.b);
            OP_GT:  sc_cmp = (bus.a > bus.b);
            OP_LT:  sc_cmp = (bus.a < bus.b);
            OP_MUL: sc_err = !MUL_ENABLE;
            default: sc_err = 1'b1;
        endcase
        sc_z = ~sc_err & (sc_res == '0);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        res_d       = res_q;
        hi_d        = hi_q;
        c_d         = c_q;
        v_d         = v_q;
        z_d         = z_q;
        cmp_d       = cmp_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul_op) begin
                    state_d  = S_MUL;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, bus.a};
                    mplier_d = bus.b;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    res_d       = sc_res;
                    hi_d        = '0;
                    c_d         = sc_c;
                    v_d         = sc_v;
                    z_d         = sc_z;
                    cmp_d       = sc_cmp;
                    err_d       = sc_err;
                end
            end
            S_MUL: begin
                // One multiplier bit per cycle, LSB first.
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    res_d       = acc_d[WIDTH-1:0];
                    hi_d        = acc_d[2*WIDTH-1:WIDTH];
                    c_d         = 1'b0;
                    v_d         = (acc_d[2*WIDTH-1:WIDTH] != '0);
                    z_d         = (acc_d == '0);
                    cmp_d       = 1'b0;
                    err_d       = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            hi_q        <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            cmp_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            hi_q        <= hi_d;
            c_q         <= c_d;
            v_q         <= v_d;
            z_q         <= z_d;
            cmp_q       <= cmp_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign bus.result_hi = hi_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_cmp  = cmp_q;
    assign bus.flag_err  = err_q;
endmodule
